// File: rtl/qbus_tty.sv
// rtl/qbus_tty.sv - QBUS console TTY (RCSR/RBUF/XCSR/XBUF); define QBUS_TTY_IRQ_EN for vectored interrupts
module qbus_tty #(
    parameter int          BAUD_DIV = 16,
    parameter int          RPLY_DLY = 2,
    parameter logic [15:0] CSR_BASE = 16'o177560,
    parameter logic [15:0] RX_VEC   = 16'o000060,
    parameter logic [15:0] TX_VEC   = 16'o000064
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] ad_in_n,
    output logic [15:0] ad_out_n,
    output logic        ad_oe,
    input  logic        sync_n,
    input  logic        din_n,
    input  logic        dout_n,
    input  logic        wtbt_n,
    input  logic        iako_n,
    output logic        rply_n,
    output logic        virq_n,
    input  logic        rx_stb,
    input  logic [7:0]  rx_dat,
    output logic        txd
);
    typedef enum logic [1:0] {IDLE, WAIT, REPLY, DONE} state_t;

    logic [15:0] ad_m, s_ad, addr, rd_data;
    logic [3:0]  st_m, st_s;
    logic        s_sync, s_din, s_dout, s_wtbt, s_sync_d, sel;
    state_t      state, state_nx;
    logic [3:0]  dly_cnt, tx_bit;
    logic        cyc_rd, cyc_iak, vec_rx;
    logic        start_rd, start_wr, start_iak, go, wr_now, wr_en, done_entry, rbuf_done;
    logic        rx_ie, tx_ie, rx_done, ovr, tx_rdy, tx_busy, xbuf_wr;
    logic [7:0]  rbuf;
    logic [9:0]  tx_sh;
    logic [15:0] baud;
    logic        rx_req, tx_req, iak_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            ad_m <= '1;
            s_ad <= '1;
            st_m <= '1;
            st_s <= '1;
        end else begin
            ad_m <= ad_in_n;
            s_ad <= ad_m;
            st_m <= {sync_n, din_n, dout_n, wtbt_n};
            st_s <= st_m;
        end
    end
    assign {s_sync, s_din, s_dout, s_wtbt} = st_s;

    // Address phase: latch on the synchronized falling edge of sync_n.
    always_ff @(posedge clk) begin
        if (reset) begin
            s_sync_d <= 1'b1;
            sel      <= 1'b0;
            addr     <= '0;
        end else begin
            s_sync_d <= s_sync;
            if (s_sync) begin
                sel <= 1'b0;
            end else if (s_sync_d) begin
                addr <= ~s_ad;
                sel  <= (~s_ad[15:3] == CSR_BASE[15:3]) && s_ad[0];
            end
        end
    end

    assign start_rd   = sel && !s_din;
    assign start_wr   = sel && s_din && !s_dout;
    assign start_iak  = !start_rd && iak_ok && !s_din;
    assign go         = start_rd || start_wr || start_iak;
    assign wr_now     = (state == IDLE) && start_wr;
    assign wr_en      = wr_now && (s_wtbt || !addr[0]);
    assign done_entry = (state == REPLY) && s_din && s_dout;
    assign rbuf_done  = done_entry && cyc_rd && !cyc_iak && (addr[2:1] == 2'd1);
    assign xbuf_wr    = wr_en && (addr[2:1] == 2'd3) && tx_rdy;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (go) state_nx = WAIT;
            WAIT:    if (dly_cnt == 4'(RPLY_DLY - 1)) state_nx = REPLY;
            REPLY:   if (s_din && s_dout) state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        rd_data = '0;
        if (cyc_iak) begin
            rd_data = vec_rx ? RX_VEC : TX_VEC;
        end else begin
            case (addr[2:1])
                2'd0:    rd_data = {8'b0, rx_done, rx_ie, 6'b0};
                2'd1:    rd_data = {ovr, 7'b0, rbuf};
                2'd2:    rd_data = {8'b0, tx_rdy, tx_ie, 6'b0};
                default: rd_data = '0;
            endcase
        end
    end

    always_comb begin
        rply_n   = (state != REPLY);
        ad_oe    = cyc_rd && ((state == WAIT) || (state == REPLY));
        ad_out_n = ad_oe ? ~rd_data : 16'hFFFF;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dly_cnt <= '0;
            cyc_rd  <= 1'b0;
            cyc_iak <= 1'b0;
            vec_rx  <= 1'b0;
        end else if (state == IDLE) begin
            dly_cnt <= '0;
            if (go) begin
                cyc_rd  <= start_rd || start_iak;
                cyc_iak <= start_iak;
                vec_rx  <= rx_req;
            end
        end else if (state == WAIT) begin
            dly_cnt <= dly_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_ie   <= 1'b0;
            tx_ie   <= 1'b0;
            rx_done <= 1'b0;
            ovr     <= 1'b0;
            rbuf    <= '0;
        end else begin
            if (wr_en && addr[2:1] == 2'd0) rx_ie <= ~s_ad[6];
            if (wr_en && addr[2:1] == 2'd2) tx_ie <= ~s_ad[6];
            // A byte arriving as RBUF is read is a fresh byte, not an overrun.
            if (rx_stb) begin
                rbuf    <= rx_dat;
                rx_done <= 1'b1;
                ovr     <= rbuf_done ? 1'b0 : (ovr || rx_done);
            end else if (rbuf_done) begin
                rx_done <= 1'b0;
                ovr     <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_rdy  <= 1'b1;
            tx_busy <= 1'b0;
            tx_sh   <= '1;
            tx_bit  <= '0;
            baud    <= '0;
        end else if (xbuf_wr) begin
            tx_sh   <= {1'b1, ~s_ad[7:0], 1'b0};
            tx_busy <= 1'b1;
            tx_rdy  <= 1'b0;
            tx_bit  <= '0;
            baud    <= '0;
        end else if (tx_busy) begin
            if (baud == 16'(BAUD_DIV - 1)) begin
                baud  <= '0;
                tx_sh <= {1'b1, tx_sh[9:1]};
                if (tx_bit == 4'd9) begin
                    tx_busy <= 1'b0;
                    tx_rdy  <= 1'b1;
                end else begin
                    tx_bit <= tx_bit + 4'd1;
                end
            end else begin
                baud <= baud + 16'd1;
            end
        end
    end
    assign txd = tx_busy ? tx_sh[0] : 1'b1;

`ifdef QBUS_TTY_IRQ_EN
    logic iako_m, s_iako, rx_lvl_d, tx_lvl_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            iako_m   <= 1'b1;
            s_iako   <= 1'b1;
            rx_lvl_d <= 1'b0;
            tx_lvl_d <= 1'b0;
            rx_req   <= 1'b0;
            tx_req   <= 1'b0;
        end else begin
            iako_m   <= iako_n;
            s_iako   <= iako_m;
            rx_lvl_d <= rx_done && rx_ie;
            tx_lvl_d <= tx_rdy && tx_ie;
            if (!rx_ie)                               rx_req <= 1'b0;
            else if (rx_done && !rx_lvl_d)            rx_req <= 1'b1;
            else if (done_entry && cyc_iak && vec_rx) rx_req <= 1'b0;
            if (!tx_ie)                                tx_req <= 1'b0;
            else if (tx_rdy && !tx_lvl_d)              tx_req <= 1'b1;
            else if (done_entry && cyc_iak && !vec_rx) tx_req <= 1'b0;
        end
    end
    assign iak_ok = !s_iako && (rx_req || tx_req);
    assign virq_n = !(rx_req || tx_req);
`else
    assign rx_req = 1'b0;
    assign tx_req = 1'b0;
    assign iak_ok = 1'b0;
    assign virq_n = 1'b1;
`endif
endmodule

// File: tb/tb_qbus_tty.sv
// tb/tb_qbus_tty.sv - directed self-checking bench for qbus_tty
module tb_qbus_tty;
    localparam int RPLY_DLY = 2;
    localparam logic [15:0] RCSR = 16'o177560, RBUF = 16'o177562,
                            XCSR = 16'o177564, XBUF = 16'o177566;

    logic        clk = 1'b0, reset = 1'b1;
    logic [15:0] ad_in_n = '1, ad_out_n;
    logic        ad_oe, rply_n, virq_n, txd;
    logic        sync_n = 1'b1, din_n = 1'b1, dout_n = 1'b1, wtbt_n = 1'b1, iako_n = 1'b1;
    logic        rx_stb = 1'b0;
    logic [7:0]  rx_dat = '0;

    int n_run = 0, n_fail = 0;

    qbus_tty #(.BAUD_DIV(16), .RPLY_DLY(RPLY_DLY)) dut (
        .clk(clk), .reset(reset), .ad_in_n(ad_in_n), .ad_out_n(ad_out_n), .ad_oe(ad_oe),
        .sync_n(sync_n), .din_n(din_n), .dout_n(dout_n), .wtbt_n(wtbt_n), .iako_n(iako_n),
        .rply_n(rply_n), .virq_n(virq_n), .rx_stb(rx_stb), .rx_dat(rx_dat), .txd(txd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %06o expected %06o", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_rply_high();
        for (int i = 0; i < 20; i++) begin
            if (rply_n) break;
            tick(1);
        end
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [15:0] d, output logic ok,
                            output int lat, output logic oe_seen);
        ad_in_n = ~a; tick(2);
        sync_n = 1'b0; tick(3);
        ad_in_n = '1; din_n = 1'b0;
        ok = 1'b0; lat = 0; oe_seen = 1'b0; d = '1;
        for (int i = 0; i < 40; i++) begin
            tick(1); lat++;
            if (ad_oe) oe_seen = 1'b1;
            if (!rply_n) begin ok = 1'b1; d = ~ad_out_n; break; end
        end
        din_n = 1'b1; wait_rply_high(); tick(2);
        sync_n = 1'b1; tick(3);
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d, input logic wt, output logic ok);
        ad_in_n = ~a; tick(2);
        sync_n = 1'b0; tick(3);
        ad_in_n = ~d; wtbt_n = wt; dout_n = 1'b0; ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (!rply_n) begin ok = 1'b1; break; end
        end
        dout_n = 1'b1; wait_rply_high(); tick(2);
        sync_n = 1'b1; wtbt_n = 1'b1; ad_in_n = '1; tick(3);
    endtask

    task automatic iack(output logic [15:0] v, output logic ok);
        iako_n = 1'b0; din_n = 1'b0; ok = 1'b0; v = '1;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (!rply_n) begin ok = 1'b1; v = ~ad_out_n; break; end
        end
        din_n = 1'b1; iako_n = 1'b1; wait_rply_high(); tick(3);
    endtask

    task automatic rx_pulse(input logic [7:0] d);
        rx_dat = d; rx_stb = 1'b1; tick(1);
        rx_stb = 1'b0; tick(1);
    endtask

    // Samples each serial bit mid-way, timed from the start-bit edge.
    logic       mon_en = 1'b0, mon_done = 1'b0;
    int         frames = 0;
    logic [9:0] bits = '0;
    always @(negedge txd) begin
        if (mon_en) begin
            frames++;
            if (frames == 1) begin
                repeat (8) @(posedge clk);
                for (int i = 0; i < 10; i++) begin
                    #1 bits[i] = txd;
                    if (i < 9) repeat (16) @(posedge clk);
                end
                mon_done = 1'b1;
            end
        end
    end

    initial begin
        logic [15:0] d, v;
        logic        ok, oe;
        int          lat;

        tick(3);
        check("rst_rply_n", {15'b0, rply_n}, 16'd1);
        check("rst_virq_n", {15'b0, virq_n}, 16'd1);
        check("rst_ad_oe", {15'b0, ad_oe}, 16'd0);
        check("rst_ad_out_n", ad_out_n, 16'hFFFF);
        check("rst_txd", {15'b0, txd}, 16'd1);
        reset = 1'b0; tick(2);

        // First edge samples din_n, then 2 sync stages' worth plus RPLY_DLY to reply.
        bus_read(XCSR, d, ok, lat, oe);
        check("xcsr_rst_ok", {15'b0, ok}, 16'd1);
        check("xcsr_rst_lat", 16'(lat), 16'(3 + RPLY_DLY));
        check("xcsr_rst_oe", {15'b0, oe}, 16'd1);
        check("xcsr_rst", d, 16'o000200);

        mon_en = 1'b1;
        bus_write(XBUF, 16'o000101, 1'b1, ok);
        check("xbuf_wr_ok", {15'b0, ok}, 16'd1);
        bus_read(XCSR, d, ok, lat, oe);
        check("xcsr_busy", d, 16'o000000);
        bus_write(XBUF, 16'o000377, 1'b1, ok);
        for (int i = 0; i < 300; i++) begin
            if (mon_done) break;
            tick(1);
        end
        check("tx_mon_done", {15'b0, mon_done}, 16'd1);
        check("tx_frame", {6'b0, bits}, {6'b0, 10'b1010000010});
        tick(20);
        bus_read(XCSR, d, ok, lat, oe);
        check("xcsr_idle", d, 16'o000200);
        tick(40);
        check("tx_frames", 16'(frames), 16'd1);
        check("tx_idle_txd", {15'b0, txd}, 16'd1);
        mon_en = 1'b0;

        rx_pulse(8'o123);
        rx_pulse(8'o123);
        bus_read(RCSR, d, ok, lat, oe);
        check("rcsr_done", d, 16'o000200);
        bus_read(RBUF, d, ok, lat, oe);
        check("rbuf_ovr", d, 16'o100123);
        bus_read(RCSR, d, ok, lat, oe);
        check("rcsr_clr", d, 16'o000000);
        rx_pulse(8'o045);
        bus_read(RBUF, d, ok, lat, oe);
        check("rbuf_no_ovr", d, 16'o000045);

        bus_write(RCSR, 16'o000100, 1'b0, ok);
        bus_read(RCSR, d, ok, lat, oe);
        check("rcsr_byte_ie", d, 16'o000100);
        bus_write(RCSR, 16'o000000, 1'b1, ok);
        bus_read(RCSR, d, ok, lat, oe);
        check("rcsr_ie_clr", d, 16'o000000);

        bus_read(16'o177570, d, ok, lat, oe);
        check("unsel_rply", {15'b0, ok}, 16'd0);
        check("unsel_oe", {15'b0, oe}, 16'd0);
        bus_write(16'o177565, 16'o000100, 1'b0, ok);
        check("odd_wr_rply", {15'b0, ok}, 16'd0);
        bus_read(XCSR, d, ok, lat, oe);
        check("odd_wr_noeff", d, 16'o000200);

`ifdef QBUS_TTY_IRQ_EN
        bus_write(XCSR, 16'o000100, 1'b1, ok);
        check("tx_irq_virq", {15'b0, virq_n}, 16'd0);
        iack(v, ok);
        check("tx_iack_ok", {15'b0, ok}, 16'd1);
        check("tx_vec", v, 16'o000064);
        check("tx_irq_clr", {15'b0, virq_n}, 16'd1);
        bus_write(XCSR, 16'o000000, 1'b1, ok);
        rx_pulse(8'o001);
        bus_write(RCSR, 16'o000100, 1'b1, ok);
        bus_write(XCSR, 16'o000100, 1'b1, ok);
        check("both_virq", {15'b0, virq_n}, 16'd0);
        iack(v, ok);
        check("both_vec1", v, 16'o000060);
        check("both_virq_mid", {15'b0, virq_n}, 16'd0);
        iack(v, ok);
        check("both_vec2", v, 16'o000064);
        check("both_virq_end", {15'b0, virq_n}, 16'd1);
        bus_write(RCSR, 16'o000000, 1'b1, ok);
        bus_read(RBUF, d, ok, lat, oe);
`else
        bus_write(XCSR, 16'o000100, 1'b1, ok);
        bus_read(XCSR, d, ok, lat, oe);
        check("tx_ie_rw", d, 16'o000300);
        check("noirq_virq", {15'b0, virq_n}, 16'd1);
        iack(v, ok);
        check("noirq_iack", {15'b0, ok}, 16'd0);
`endif
        bus_write(XCSR, 16'o000000, 1'b1, ok);

        bus_write(XBUF, 16'o000000, 1'b1, ok);
        tick(20);
        check("tx_mid_txd", {15'b0, txd}, 16'd0);
        reset = 1'b1; tick(1);
        check("tx_abort_txd", {15'b0, txd}, 16'd1);
        reset = 1'b0; tick(2);
        bus_read(XCSR, d, ok, lat, oe);
        check("tx_abort_xcsr", d, 16'o000200);

        ad_in_n = ~XCSR; tick(2);
        sync_n = 1'b0; tick(3);
        ad_in_n = '1; din_n = 1'b0; ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (!rply_n) begin ok = 1'b1; break; end
        end
        check("midbus_rply", {15'b0, ok}, 16'd1);
        reset = 1'b1; tick(1);
        check("midbus_rst_rply", {15'b0, rply_n}, 16'd1);
        check("midbus_rst_oe", {15'b0, ad_oe}, 16'd0);
        reset = 1'b0; din_n = 1'b1; sync_n = 1'b1; tick(5);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
